button_debouncer: RTL and testbench
===================================

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 2000000, stable-level cycles required to accept an edge (10 ms at 200 MHz); legal range >= 2.
REQ-002 SHALL have parameter LONG_PRESS_CYCLES, default 200000000, cycles in HELD before long_pulse (1 s at 200 MHz); legal range >= 2.
REQ-003 SHALL have parameter BTN_ACTIVE_LOW, default 1; 1 means button=0 is pressed, 0 means button=1 is pressed.
REQ-004 SHALL have port clk_200mhz  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port button  input  1  raw asynchronous pushbutton pin.
REQ-007 SHALL have port btn_level  output  1  debounced pressed level, 1 means pressed.
REQ-008 SHALL have port press_pulse  output  1  one-cycle strobe per accepted press; feeds the LED counter's increment.
REQ-009 SHALL have port release_pulse  output  1  one-cycle strobe per accepted release.
REQ-010 SHALL have port long_pulse  output  1  one-cycle strobe, at most once per press.
REQ-011 SHALL have port press_count  output  8  count of accepted presses, wrapping.

Function
REQ-012 SHALL normalise button to a pressed bit, then pass it through a 2-flop synchroniser (sync1, sync2); only sync2 drives the FSM.
REQ-013 SHALL implement FSM states IDLE, PRESS_WAIT, HELD and RELEASE_WAIT, plus a debounce counter and a hold counter, each sized for its parameter.
REQ-014 IDLE: when sync2=1, SHALL go to PRESS_WAIT and clear the debounce counter; otherwise stay in IDLE.
REQ-015 PRESS_WAIT: when sync2=0, SHALL return to IDLE with no strobe (bounce rejected).
REQ-016 PRESS_WAIT: when debounce counter == DEBOUNCE_CYCLES-1 and sync2=1, SHALL go to HELD, pulse press_pulse, set btn_level=1, clear the hold counter and the long-fired flag; otherwise increment the debounce counter.
REQ-017 Press latency: with edge N the first edge sampling a stable press into sync1, press_pulse SHALL be high exactly in the cycle after edge N+DEBOUNCE_CYCLES+2.
REQ-018 HELD: the hold counter SHALL increment each cycle and saturate.
REQ-019 HELD: when the hold counter == LONG_PRESS_CYCLES-1 and the long-fired flag is 0, SHALL pulse long_pulse and set the flag; this is at edge HELD-entry+LONG_PRESS_CYCLES.
REQ-020 HELD: when sync2=0, SHALL go to RELEASE_WAIT and clear the debounce counter; the hold counter freezes.
REQ-021 RELEASE_WAIT: when sync2=1, SHALL return to HELD with no strobe; the hold counter and flag are kept, so long_pulse is never repeated.
REQ-022 RELEASE_WAIT: when debounce counter == DEBOUNCE_CYCLES-1 and sync2=0, SHALL go to IDLE, pulse release_pulse and clear btn_level.
REQ-023 press_count SHALL increment by 1 on the same edge press_pulse rises, modulo 256 (255 -> 0).
REQ-024 All outputs SHALL be registered; press_pulse, release_pulse and long_pulse SHALL each be high at most one cycle per event and never high simultaneously.

Reset
REQ-025 rst_n=0 SHALL immediately force the following: FSM=IDLE, counters=0, long-fired flag=0, sync1/sync2=0 (not pressed), btn_level=0, all strobes=0, press_count=0.
REQ-026 Reset mid-press SHALL discard all progress; after release of reset, a still-held button SHALL be debounced afresh and produce press_pulse per REQ-017 timing.
REQ-027 rst_n deassertion SHALL be used synchronised to clk_200mhz by the instantiating top.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=16, BTN_ACTIVE_LOW=1)
REQ-028 Clean press: button 1->0 sampled at edge N and held -> exactly one press_pulse, after edge N+6; btn_level=1 from the same edge; press_count 0->1.
REQ-029 Bounce: button low for 3 cycles, high 1 cycle, repeated 5 times, then high -> no strobes; btn_level=0; press_count=0.
REQ-030 Long press: hold 40 cycles past press_pulse -> exactly one long_pulse 16 cycles after press_pulse; no further long_pulse; then release -> release_pulse after 6 cycles.
REQ-031 Release bounce: while HELD, button high 2 cycles then low -> no release_pulse; state stays HELD; long_pulse count stays 1 for the press.
REQ-032 Wrap: 256 clean press/release cycles -> press_count returns to 0; 256 press_pulses observed.
REQ-033 Reset mid-press: assert rst_n=0 in PRESS_WAIT with button held, deassert -> all outputs 0 during reset; press_pulse 6 cycles after the first post-reset sampling edge.

Source files
------------

// File: rtl/button_debouncer.sv
// button_debouncer: synchronises and debounces a pushbutton, emitting press/release/long-press strobes and a press count.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES   = 2000000,
  parameter int LONG_PRESS_CYCLES = 200000000,
  parameter bit BTN_ACTIVE_LOW    = 1'b1
) (
  input  logic       clk_200mhz,
  input  logic       rst_n,
  input  logic       button,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic [7:0] press_count
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_PRESS_CYCLES);
  localparam logic [DW-1:0] D_MAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] H_MAX = HW'(LONG_PRESS_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;
  state_t state_q, state_d;
  logic sync1_q, sync2_q, fired_q, fired_d, level_q, level_d;
  logic press_q, press_d, rel_q, rel_d, long_q, long_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [7:0] count_q, count_d;
  logic pressed;
  assign pressed = BTN_ACTIVE_LOW ? ~button : button;
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    hcnt_d  = hcnt_q;
    fired_d = fired_q;
    level_d = level_q;
    count_d = count_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = 1'b0;
    case (state_q)
      IDLE: if (sync2_q) begin
        state_d = PRESS_WAIT;
        dcnt_d  = '0;
      end
      PRESS_WAIT: if (!sync2_q) state_d = IDLE;
        else if (dcnt_q == D_MAX) begin
          state_d = HELD;
          press_d = 1'b1;
          level_d = 1'b1;
          hcnt_d  = '0;
          fired_d = 1'b0;
          count_d = count_q + 8'd1;
        end else dcnt_d = dcnt_q + DW'(1);
      HELD: if (!sync2_q) begin
        state_d = RELEASE_WAIT;
        dcnt_d  = '0;
      end else begin
        hcnt_d = (hcnt_q == H_MAX) ? hcnt_q : hcnt_q + HW'(1);
        long_d = (hcnt_q == H_MAX) && !fired_q;
        fired_d = fired_q | long_d;
      end
      RELEASE_WAIT: if (sync2_q) state_d = HELD;
        else if (dcnt_q == D_MAX) begin
          state_d = IDLE;
          rel_d   = 1'b1;
          level_d = 1'b0;
        end else dcnt_d = dcnt_q + DW'(1);
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_200mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dcnt_q  <= '0;
      hcnt_q  <= '0;
      fired_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      sync1_q <= pressed;
      sync2_q <= sync1_q;
      dcnt_q  <= dcnt_d;
      hcnt_q  <= hcnt_d;
      fired_q <= fired_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      count_q <= count_d;
    end
  end
  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign long_pulse    = long_q;
  assign press_count   = count_q;
endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: directed stimulus with a timed-strobe scoreboard for button_debouncer (D=4, L=16, active-low).
module tb_button_debouncer;
  logic clk = 1'b0, rst_n = 1'b0, button = 1'b1;
  logic btn_level, press_pulse, release_pulse, long_pulse;
  logic [7:0] press_count;
  typedef struct {int kind; int at;} ev_t;
  ev_t q[$];
  int cyc = 0, total = 0, bad = 0, exp_count = 0, p_edge;
  button_debouncer #(.DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(16), .BTN_ACTIVE_LOW(1'b1)) dut (
    .clk_200mhz(clk), .rst_n(rst_n), .button(button), .btn_level(btn_level),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .long_pulse(long_pulse),
    .press_count(press_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d cyc=%0d", tag, obs, exp, cyc);
    end
  endtask
  // kind 0=press, 1=release, 2=long; expected strobe seen at the negedge where cyc==at
  task automatic drive(input logic v, input int kind, input bit lng);
    @(negedge clk);
    button = v;
    q.push_back('{kind, cyc + 7});
    if (lng) q.push_back('{2, cyc + 23});
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_level"}, btn_level, 0);
    chk({tag, "_strobes"}, {press_pulse, release_pulse, long_pulse}, 0);
    chk({tag, "_count"}, press_count, 0);
  endtask
  always @(negedge clk) begin
    logic [2:0] p;
    ev_t e;
    p = {long_pulse, release_pulse, press_pulse};
    if (p != 3'b000) begin
      chk("strobe_onehot", $onehot(p), 1);
      for (int k = 0; k < 3; k++) if (p[k]) begin
        e = (q.size() != 0) ? q.pop_front() : '{-1, -1};
        chk("strobe_kind", k, e.kind);
        chk("strobe_time", cyc, e.at);
        if (k == 0) begin
          exp_count = (exp_count + 1) % 256;
          chk("count_at_press", press_count, exp_count);
          chk("level_at_press", btn_level, 1);
        end
        if (k == 1) chk("level_at_release", btn_level, 0);
      end
    end
  end
  initial begin
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    repeat (5) begin
      button = 1'b0;
      repeat (3) @(negedge clk);
      button = 1'b1;
      @(negedge clk);
    end
    repeat (12) @(negedge clk);
    chk_all_zero("bounce");
    drive(1'b0, 0, 1'b1);
    repeat (5) @(negedge clk);
    chk("press_not_early", btn_level, 0);
    repeat (2) @(negedge clk);
    chk("press_level", btn_level, 1);
    chk("press_count1", press_count, 1);
    repeat (40) @(negedge clk);
    chk("long_consumed", q.size(), 0);
    drive(1'b1, 1, 1'b0);
    repeat (10) @(negedge clk);
    chk("release_level", btn_level, 0);
    chk("release_pending", q.size(), 0);
    drive(1'b0, 0, 1'b1);
    repeat (30) @(negedge clk);
    button = 1'b1;
    repeat (2) @(negedge clk);
    button = 1'b0;
    repeat (10) @(negedge clk);
    chk("rbounce_level", btn_level, 1);
    chk("rbounce_pending", q.size(), 0);
    repeat (20) @(negedge clk);
    drive(1'b1, 1, 1'b0);
    repeat (10) @(negedge clk);
    chk("rbounce_release", btn_level, 0);
    chk("count2", press_count, 2);
    for (int i = 0; i < 256; i++) begin
      drive(1'b0, 0, 1'b0);
      repeat (8) @(negedge clk);
      drive(1'b1, 1, 1'b0);
      repeat (8) @(negedge clk);
      chk("wrap_count", press_count, (2 + i + 1) % 256);
    end
    chk("wrap_pending", q.size(), 0);
    @(negedge clk);
    button = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset_now");
    exp_count = 0;
    repeat (3) @(negedge clk);
    chk_all_zero("midreset_hold");
    rst_n = 1'b1;
    p_edge = cyc + 1;
    q.push_back('{0, p_edge + 6});
    repeat (5) @(negedge clk);
    chk("postreset_not_early", btn_level, 0);
    repeat (2) @(negedge clk);
    chk("postreset_level", btn_level, 1);
    chk("postreset_count", press_count, 1);
    drive(1'b1, 1, 1'b0);
    repeat (10) @(negedge clk);
    chk("final_level", btn_level, 0);
    chk("final_pending", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
